multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
// - Moore control FSM that sequences the multicycle RISC-V datapath (shared ALU, unified memory, IR).
// - Supports RV32I subset: lw, sw, R-type, I-type ALU, beq, jal.
// - Replaces single-cycle main decode when core is built multicycle.
// - Drives mux selects and write enables each cycle; stalls on a memory ready handshake.
// PARAMETERS
// - USE_MEM_READY  1  1: memory states wait for mem_ready; 0: mem_ready treated as constant 1
// PORTS
// - clk          in   1  single clock, all state updates on rising edge
// - rst_n        in   1  synchronous, active-low reset
// - op           in   7  opcode from IR[6:0]; valid from DECODE onward
// - zero         in   1  ALU zero flag, used in BEQ
// - mem_ready    in   1  memory completes current access this cycle
// - pc_write     out  1  PC register enable = pc_update | (branch & zero)
// - adr_src      out  1  memory address: 0 = PC, 1 = ALUOut/Result
// - mem_write    out  1  memory write strobe
// - ir_write     out  1  IR and OldPC load enable
// - res_src      out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
// - alu_src_a    out  2  00 = PC, 01 = OldPC, 10 = rs1 reg A
// - alu_src_b    out  2  00 = reg WD, 01 = ImmExt, 10 = const 4
// - alu_op       out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
// - imm_src      out  2  from op: I = 00, S = 01, B = 10, J = 11; others 00
// - reg_write    out  1  register file write enable
// - instr_done   out  1  one-cycle pulse in the final state of each instruction
// - illegal_op   out  1  one-cycle pulse in DECODE on unsupported opcode
// BEHAVIOUR
// - Clock and reset
//   - Clock: clk. Reset: rst_n, synchronous, active-low.
//   - While rst_n = 0, next state is FETCH.
//   - While rst_n = 0, pc_write, ir_write, mem_write, reg_write, instr_done and illegal_op are forced to 0.
//   - Mid-instruction reset: abandons the instruction on the next edge. No write enable fires during the reset cycle.
// - Outputs are a function of state only, except:
//   - imm_src is decoded from op.
//   - pc_write and ir_write are qualified by mem_ready in FETCH.
//   - pc_write uses zero in BEQ.
// - Default in every state: all enables 0, selects 00.
// - States, active outputs and transitions:
//   - FETCH: adr_src=0, a=00, b=10, alu_op=00, res_src=10; ir_write = pc_update = mem_ready. Stay until mem_ready, then DECODE.
//   - DECODE: a=01, b=01, alu_op=00 (branch target into ALUOut).
//     - op 3 or 35 -> MEMADR; 51 -> EXEC_R; 19 -> EXEC_I; 99 -> BEQ; 111 -> JAL.
//     - Any other op -> FETCH with illegal_op=1 and instr_done=1.
//   - MEMADR: a=10, b=01, alu_op=00. op 3 -> MEMREAD, else MEMWRITE.
//   - MEMREAD: adr_src=1, res_src=00. Stay until mem_ready, then MEMWB.
//   - MEMWB: res_src=01, reg_write=1, instr_done=1 -> FETCH.
//   - MEMWRITE: adr_src=1, res_src=00, mem_write=1, held until mem_ready. instr_done=1 in the mem_ready cycle -> FETCH.
//   - EXEC_R: a=10, b=00, alu_op=10 -> ALUWB.
//   - EXEC_I: a=10, b=01, alu_op=10 -> ALUWB.
//   - ALUWB: res_src=00, reg_write=1, instr_done=1 -> FETCH.
//   - BEQ: a=10, b=00, alu_op=01, res_src=00, branch=1; pc_write=zero; instr_done=1 -> FETCH.
//   - JAL: a=01, b=10, alu_op=00, res_src=00, pc_update=1 -> ALUWB.
// - Latency with mem_ready=1 (cycles): lw 5, sw 4, R/I 4, beq 3, jal 4.
//   - Each low mem_ready cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
// - Boundary rules:
//   - op is ignored in FETCH.
//   - mem_ready is ignored in non-memory states.
//   - Unreachable state encodings -> FETCH with no enables asserted.
// STRUCTURE
// - Shared package rv_ctrl_pkg holds:
//   - Opcode constants: OP_LW=7'd3, OP_SW=7'd35, OP_R=7'd51, OP_I=7'd19, OP_BEQ=7'd99, OP_JAL=7'd111.
//   - 4-bit state encoding localparams.
//   - Select encodings for res_src, alu_src_a, alu_src_b and alu_op.
// - One sub-module, imm_src_deco: combinational op -> imm_src.
// - FSM: one registered state, one combinational next-state/output block.
// TESTING
// - Reset: rst_n=0 for 2 cycles in any state -> state FETCH, all enables 0. Release with mem_ready=1 -> ir_write=1 and pc_write=1 in first cycle.
// - lw, op=3, mem_ready=1: visits FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 with res_src=01 in cycle 5; instr_done pulses once.
// - sw, op=35, mem_ready low 3 cycles in MEMWRITE: mem_write held 4 cycles, reg_write never 1, instr_done only in the mem_ready cycle.
// - beq, op=99: zero=1 -> pc_write=1 in cycle 3; zero=0 -> pc_write=0; total 3 cycles.
// - jal, op=111: pc_write=1 in JAL with a=01, b=10; then reg_write=1 in ALUWB; imm_src=11 throughout.
// - Illegal op=7'd0: DECODE pulses illegal_op=1 and instr_done=1, returns to FETCH, no write enable asserted after the FETCH cycle.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the multicycle RV32I control path: opcodes, FSM
// state encodings and datapath select encodings.
package rv_ctrl_pkg;

    // Supported opcodes (IR[6:0])
    localparam logic [6:0] OP_LW  = 7'd3;
    localparam logic [6:0] OP_SW  = 7'd35;
    localparam logic [6:0] OP_R   = 7'd51;
    localparam logic [6:0] OP_I   = 7'd19;
    localparam logic [6:0] OP_BEQ = 7'd99;
    localparam logic [6:0] OP_JAL = 7'd111;

    // FSM state encodings; 11..15 are unreachable
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_EXEC_I   = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    // Result mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    // ALU operand B mux
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Immediate format
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage : rv_ctrl_pkg

// File: rtl/imm_src_deco.sv
// Immediate-format decoder: maps the opcode straight to the imm_src select,
// independent of the FSM state.
module imm_src_deco
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    // Opcode to immediate format; unsupported opcodes fall back to I-format
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves imm_src unassigned (no latch).
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule : imm_src_deco

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I datapath (lw, sw, R, I, beq, jal).
// Outputs depend on state only, apart from imm_src (from op), the mem_ready
// qualification in FETCH/MEMWRITE and the zero-qualified branch in BEQ.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] res_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_op
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       mem_rdy;

    // Raw (ungated) enables produced by the state decode
    logic pc_update;
    logic branch;
    logic mem_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;
    logic instr_done_raw;
    logic illegal_op_raw;

    assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

    imm_src_deco u_imm_src_deco (
        .op      (op),
        .imm_src (imm_src)
    );

    // Next-state and per-state control decode
    always_comb begin
        state_d        = S_FETCH;
        adr_src        = 1'b0;
        res_src        = 2'b00;
        alu_src_a      = 2'b00;
        alu_src_b      = 2'b00;
        alu_op         = 2'b00;
        pc_update      = 1'b0;
        branch         = 1'b0;
        mem_write_raw  = 1'b0;
        ir_write_raw   = 1'b0;
        reg_write_raw  = 1'b0;
        instr_done_raw = 1'b0;
        illegal_op_raw = 1'b0;

        case (state_q)
            S_FETCH: begin
                adr_src      = 1'b0;
                alu_src_a    = SRCA_PC;
                alu_src_b    = SRCB_FOUR;
                alu_op       = ALU_ADD;
                res_src      = RES_ALURESULT;
                ir_write_raw = mem_rdy;
                pc_update    = mem_rdy;
                state_d      = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Precompute PC-relative branch target into ALUOut
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d        = S_FETCH;
                        illegal_op_raw = 1'b1;
                        instr_done_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                res_src = RES_ALUOUT;
                state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                res_src        = RES_DATA;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe held until the memory accepts the store
                adr_src        = 1'b1;
                res_src        = RES_ALUOUT;
                mem_write_raw  = 1'b1;
                instr_done_raw = mem_rdy;
                state_d        = mem_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_REG;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                res_src        = RES_ALUOUT;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
                state_d        = S_FETCH;
            end
            S_BEQ: begin
                // Compare rs1/rs2; ALUOut already holds the target
                alu_src_a      = SRCA_REG;
                alu_src_b      = SRCB_REG;
                alu_op         = ALU_SUB;
                res_src        = RES_ALUOUT;
                branch         = 1'b1;
                instr_done_raw = 1'b1;
                state_d        = S_FETCH;
            end
            S_JAL: begin
                // PC <- target (ALUOut); ALU forms OldPC+4 for the link write
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                res_src   = RES_ALUOUT;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Enables are suppressed during reset so an abandoned instruction writes nothing
    always_comb begin
        pc_write   = rst_n & (pc_update | (branch & zero));
        ir_write   = rst_n & ir_write_raw;
        mem_write  = rst_n & mem_write_raw;
        reg_write  = rst_n & reg_write_raw;
        instr_done = rst_n & instr_done_raw;
        illegal_op = rst_n & illegal_op_raw;
    end

    // State register with synchronous active-low reset to FETCH
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

endmodule : multicycle_ctrl

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares the full control word against hand-derived values.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] res_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.USE_MEM_READY(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .res_src    (res_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .reg_write  (reg_write),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word layout:
    // {pc_write, adr_src, mem_write, ir_write, res_src, a, b, alu_op, imm_src, reg_write, instr_done, illegal_op}
    function automatic logic [16:0] cw(
        input logic pcw, input logic adr, input logic mw, input logic irw,
        input logic [1:0] res, input logic [1:0] a, input logic [1:0] b,
        input logic [1:0] aop, input logic [1:0] imm,
        input logic rw, input logic done, input logic ill);
        return {pcw, adr, mw, irw, res, a, b, aop, imm, rw, done, ill};
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply inputs mid-cycle, let combinational outputs settle, then compare
    task automatic step(input string tag, input logic rn, input logic [6:0] o,
                        input logic z, input logic mr, input logic [16:0] exp);
        @(negedge clk);
        rst_n     = rn;
        op        = o;
        zero      = z;
        mem_ready = mr;
        #1;
        check(tag, {pc_write, adr_src, mem_write, ir_write, res_src, alu_src_a,
                    alu_src_b, alu_op, imm_src, reg_write, instr_done, illegal_op}, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = 7'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset: first cycle state may be unknown, only enables are defined
        @(negedge clk);
        #1;
        check("rst_en_c1", {11'd0, pc_write, ir_write, mem_write, reg_write, instr_done, illegal_op}, 17'd0);
        step("rst_c2_fetch", 0, 7'd0, 0, 1, cw(0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));

        // lw, mem_ready=1 throughout: 5 cycles
        step("lw_fetch",   1, 7'd3, 0, 1, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));
        step("lw_decode",  1, 7'd3, 0, 1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0));
        step("lw_memadr",  1, 7'd3, 0, 1, cw(0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0,0,0));
        step("lw_memread", 1, 7'd3, 0, 1, cw(0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0));
        step("lw_memwb",   1, 7'd3, 0, 1, cw(0,0,0,0,2'b01,2'b00,2'b00,2'b00,2'b00,1,1,0));

        // sw: one stalled fetch, then three stalled MEMWRITE cycles
        step("sw_fetch_stall", 1, 7'd35, 0, 0, cw(0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b01,0,0,0));
        step("sw_fetch",       1, 7'd35, 0, 1, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b01,0,0,0));
        step("sw_decode",      1, 7'd35, 0, 1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b01,0,0,0));
        step("sw_memadr",      1, 7'd35, 0, 0, cw(0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b01,0,0,0));
        for (int i = 0; i < 3; i++)
            step("sw_memwrite_wait", 1, 7'd35, 0, 0, cw(0,1,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0,0,0));
        step("sw_memwrite_done", 1, 7'd35, 0, 1, cw(0,1,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0,1,0));

        // R-type; mem_ready low in EXEC_R must be ignored
        step("r_fetch",  1, 7'd51, 0, 1, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));
        step("r_decode", 1, 7'd51, 0, 1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0));
        step("r_exec",   1, 7'd51, 0, 0, cw(0,0,0,0,2'b00,2'b10,2'b00,2'b10,2'b00,0,0,0));
        step("r_aluwb",  1, 7'd51, 0, 0, cw(0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,1,1,0));

        // I-type ALU
        step("i_fetch",  1, 7'd19, 0, 1, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));
        step("i_decode", 1, 7'd19, 0, 1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0));
        step("i_exec",   1, 7'd19, 0, 1, cw(0,0,0,0,2'b00,2'b10,2'b01,2'b10,2'b00,0,0,0));
        step("i_aluwb",  1, 7'd19, 0, 1, cw(0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,1,1,0));

        // beq taken (zero=1)
        step("beq_t_fetch",  1, 7'd99, 1, 1, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b10,0,0,0));
        step("beq_t_decode", 1, 7'd99, 1, 1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0,0,0));
        step("beq_t_beq",    1, 7'd99, 1, 1, cw(1,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0,1,0));

        // beq not taken (zero=0)
        step("beq_n_fetch",  1, 7'd99, 0, 1, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b10,0,0,0));
        step("beq_n_decode", 1, 7'd99, 0, 1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0,0,0));
        step("beq_n_beq",    1, 7'd99, 0, 1, cw(0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0,1,0));

        // jal
        step("jal_fetch",  1, 7'd111, 0, 1, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b11,0,0,0));
        step("jal_decode", 1, 7'd111, 0, 1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b11,0,0,0));
        step("jal_jal",    1, 7'd111, 0, 1, cw(1,0,0,0,2'b00,2'b01,2'b10,2'b00,2'b11,0,0,0));
        step("jal_aluwb",  1, 7'd111, 0, 1, cw(0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b11,1,1,0));

        // Illegal opcode 0: pulse in DECODE, back to FETCH with nothing enabled
        step("ill_fetch",  1, 7'd0, 0, 1, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));
        step("ill_decode", 1, 7'd0, 0, 1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,1,1));
        step("ill_refetch_stall", 1, 7'd0, 0, 0, cw(0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));

        // Mid-instruction reset in MEMWB: no write, then restart at FETCH
        step("mr_fetch",   1, 7'd3, 0, 1, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));
        step("mr_decode",  1, 7'd3, 0, 1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0));
        step("mr_memadr",  1, 7'd3, 0, 1, cw(0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0,0,0));
        step("mr_memread", 1, 7'd3, 0, 1, cw(0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0));
        step("mr_memwb_rst", 0, 7'd3, 0, 1, cw(0,0,0,0,2'b01,2'b00,2'b00,2'b00,2'b00,0,0,0));
        step("mr_refetch", 1, 7'd3, 0, 1, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_multicycle_ctrl
